// File: rtl/alu_if.sv
// Request/response bundle between an issuing stage and alu_exec_unit.
interface alu_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (output start, alu_op, func, a, b,
                    input  busy, done, result, hi, zero, overflow, illegal);
    modport slave  (input  start, alu_op, func, a, b,
                    output busy, done, result, hi, zero, overflow, illegal);
endinterface

// File: rtl/alu_exec_unit.sv
// Integer execute unit: single-cycle add/sub/logic/slt, optional multi-cycle
// shift-add multiplier built only when ALU_MUL_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst,
    alu_if.slave io
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] K_ADD = 3'd0;
    localparam logic [2:0] K_SUB = 3'd1;
    localparam logic [2:0] K_AND = 3'd2;
    localparam logic [2:0] K_OR  = 3'd3;
    localparam logic [2:0] K_XOR = 3'd4;
    localparam logic [2:0] K_SLT = 3'd5;
    localparam logic [2:0] K_MUL = 3'd6;
    localparam logic [2:0] K_ILL = 3'd7;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic [1:0]       state;
    logic [2:0]       kind;
    logic [WIDTH-1:0] b_eff, sum, alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] result_q, hi_q;
    logic             zero_q, ovf_q, ill_q;

    // Full 011000 outranks the x000 add pattern; outside an R-type mult build it is illegal.
    always_comb begin
        kind = K_ILL;
        case (io.alu_op)
            2'b00: kind = K_ADD;
            2'b01: kind = K_SUB;
            default: begin
                if (io.func == 6'b011000)
                    kind = (io.alu_op == 2'b10 && MUL_EN) ? K_MUL : K_ILL;
                else begin
                    case (io.func[3:0])
                        4'b0000, 4'b1000: kind = K_ADD;
                        4'b0010:          kind = (io.alu_op == 2'b10) ? K_SUB : K_ILL;
                        4'b0100, 4'b1100: kind = K_AND;
                        4'b0101, 4'b1101: kind = K_OR;
                        4'b0110, 4'b1110: kind = K_XOR;
                        4'b1010:          kind = K_SLT;
                        default:          kind = K_ILL;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        b_eff   = (kind == K_SUB) ? ~io.b : io.b;
        sum     = io.a + b_eff + {{(WIDTH-1){1'b0}}, kind == K_SUB};
        alu_res = '0;
        alu_ovf = 1'b0;
        case (kind)
            K_ADD, K_SUB: begin
                alu_res = sum;
                alu_ovf = (io.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != io.a[WIDTH-1]);
            end
            K_AND: alu_res = io.a & io.b;
            K_OR:  alu_res = io.a | io.b;
            K_XOR: alu_res = io.a ^ io.b;
            K_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(io.a) < $signed(io.b)};
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [WIDTH:0]     psum;

    // prod = {partial high, remaining multiplier bits}; each step adds then shifts right.
    always_comb begin
        psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {psum, prod[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
`ifdef ALU_MUL_EN
            cnt      <= '0;
            mcand    <= '0;
            prod     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (!io.start)
                        state <= S_IDLE;
`ifdef ALU_MUL_EN
                    else if (kind == K_MUL) begin
                        state <= S_MUL;
                        mcand <= io.a;
                        prod  <= {{WIDTH{1'b0}}, io.b};
                        cnt   <= CW'(WIDTH-1);
                    end
`endif
                    else begin
                        state    <= S_DONE;
                        result_q <= alu_res;
                        zero_q   <= (alu_res == '0);
                        ovf_q    <= alu_ovf;
                        ill_q    <= (kind == K_ILL);
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    prod <= prod_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state    <= S_DONE;
                        result_q <= prod_nxt[WIDTH-1:0];
                        hi_q     <= prod_nxt[2*WIDTH-1:WIDTH];
                        zero_q   <= (prod_nxt[WIDTH-1:0] == '0);
                        ovf_q    <= 1'b0;
                        ill_q    <= 1'b0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io.busy     = (state == S_MUL);
    assign io.done     = (state == S_DONE);
    assign io.result   = result_q;
    assign io.hi       = hi_q;
    assign io.zero     = zero_q;
    assign io.overflow = ovf_q;
    assign io.illegal  = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, hand-written
// corner sequences and randomized ops against a behavioural model.
module tb_alu_exec_unit;
    localparam int W = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(W)) bus ();
    alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(bus));

    int total = 0;
    int bad   = 0;
    logic [W-1:0] model_hi;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
        logic         ill;
        int           lat;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   func;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        logic         ill;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: arithmetic done in wide signed/unsigned integers, not bit tricks.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] prev_hi);
        exp_t   e;
        string  k;
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.hi = prev_hi; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1; e.res = '0;
        if (op == 2'b00) k = "add";
        else if (op == 2'b01) k = "sub";
        else if (f == 6'b011000) k = (op == 2'b10 && MUL_EN) ? "mul" : "ill";
        else begin
            casez (f[3:0])
                4'b?000: k = "add";
                4'b0010: k = (op == 2'b10) ? "sub" : "ill";
                4'b?100: k = "and";
                4'b?101: k = "or";
                4'b?110: k = "xor";
                4'b1010: k = "slt";
                default: k = "ill";
            endcase
        end
        case (k)
            "add": begin s = sa + sb; e.res = W'(s); e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            "sub": begin s = sa - sb; e.res = W'(s); e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            "and": e.res = a & b;
            "or":  e.res = a | b;
            "xor": e.res = a ^ b;
            "slt": e.res = (sa < sb) ? 1 : 0;
            "mul": begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; e.hi = p[63:32]; e.lat = W + 1; end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Issue one op, wait (bounded) for done, check latency, busy span and outputs.
    task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input string nm, output exp_t e);
        int lat, bc;
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = op; bus.func = f; bus.a = a; bus.b = b;
        e = model(op, f, a, b, model_hi);
        lat = 0; bc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) bc++;
            // mid-operation start pulse with unrelated operands must be ignored
            bus.start  = (lat == 5);
            bus.alu_op = 2'($urandom);
            bus.func   = 6'($urandom);
            bus.a      = $urandom;
            bus.b      = $urandom;
        end while (!bus.done && lat < 100);
        bus.start = 1'b0;
        chk({nm, ".lat"},  64'(lat), 64'(e.lat));
        chk({nm, ".busy"}, 64'(bc),  64'(e.lat - 1));
        chk({nm, ".hi"},   64'(bus.hi), 64'(e.hi));
        chk({nm, ".ill"},  64'(bus.illegal), 64'(e.ill));
        model_hi = e.hi;
    endtask

    task automatic chk_out(input string nm, input exp_t e);
        chk({nm, ".res"},  64'(bus.result),   64'(e.res));
        chk({nm, ".zero"}, 64'(bus.zero),     64'(e.zero));
        chk({nm, ".ovf"},  64'(bus.overflow), 64'(e.ovf));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t vt[$];
    exp_t e;
    logic [5:0] fl [9];

    initial begin
        bus.start = 1'b0; bus.alu_op = '0; bus.func = '0; bus.a = '0; bus.b = '0;
        model_hi = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst.busy", 64'(bus.busy), 0);
        chk("rst.done", 64'(bus.done), 0);
        chk("rst.res",  64'(bus.result), 0);
        chk("rst.hi",   64'(bus.hi), 0);
        chk("rst.zero", 64'(bus.zero), 1);
        chk("rst.ovf",  64'(bus.overflow), 0);
        chk("rst.ill",  64'(bus.illegal), 0);

        // op, func, a, b, result, zero, ovf, illegal
        vt.push_back('{2'b00, 6'h00, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 1, 0});
        vt.push_back('{2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0});
        vt.push_back('{2'b10, 6'h02, 32'h5,         32'h5,         32'h0,         1, 0, 0});
        vt.push_back('{2'b11, 6'h02, 32'h5,         32'h5,         32'h0,         1, 0, 1});
        vt.push_back('{2'b01, 6'h00, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 1, 0});
        vt.push_back('{2'b10, 6'h04, 32'hF0F0,      32'hFF00,      32'hF000,      0, 0, 0});
        vt.push_back('{2'b11, 6'h05, 32'h0F,        32'hF0,        32'hFF,        0, 0, 0});
        vt.push_back('{2'b10, 6'h06, 32'hFF,        32'hFF,        32'h0,         1, 0, 0});
        vt.push_back('{2'b11, 6'h08, 32'h1,         32'h2,         32'h3,         0, 0, 0});
        vt.push_back('{2'b10, 6'h07, 32'h1,         32'h2,         32'h0,         1, 0, 1});
        vt.push_back('{2'b10, 6'h2A, 32'h1,         32'hFFFF_FFFF, 32'h0,         1, 0, 0});
        vt.push_back('{2'b00, 6'h00, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, 0});
        vt.push_back('{2'b01, 6'h00, 32'h0,         32'h1,         32'hFFFF_FFFF, 0, 0, 0});
        vt.push_back('{2'b11, 6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         0, 0, 0});
        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].func, vt[i].a, vt[i].b, $sformatf("vec%0d", i), e);
            chk($sformatf("vec%0d.res", i),  64'(bus.result),   64'(vt[i].res));
            chk($sformatf("vec%0d.zero", i), 64'(bus.zero),     64'(vt[i].zero));
            chk($sformatf("vec%0d.ovf", i),  64'(bus.overflow), 64'(vt[i].ovf));
            chk($sformatf("vec%0d.tbl_ill", i), 64'(bus.illegal), 64'(vt[i].ill));
        end

        // mult with mid-op start pulse; without the multiplier it is an illegal single-cycle op
        run_op(2'b10, 6'b011000, 32'hFFFF_FFFF, 32'h2, "mul", e);
        chk_out("mul", e);
        if (MUL_EN) begin
            chk("mul.tbl_hi",  64'(bus.hi), 64'h1);
            chk("mul.tbl_res", 64'(bus.result), 64'hFFFF_FFFE);
        end else begin
            chk("mul.tbl_hi",  64'(bus.hi), 64'h0);
            chk("mul.tbl_ill", 64'(bus.illegal), 64'h1);
        end
        @(negedge clk);
        chk("mul.done_pulse", 64'(bus.done), 0);

        // back-to-back single-cycle ops
        bus.start = 1'b1; bus.alu_op = 2'b00; bus.a = 32'd3; bus.b = 32'd4;
        @(negedge clk);
        chk("b2b.done0", 64'(bus.done), 1);
        chk("b2b.res0",  64'(bus.result), 7);
        bus.alu_op = 2'b10; bus.func = 6'b000110; bus.a = 32'hF0; bus.b = 32'hFF;
        @(negedge clk);
        chk("b2b.done1", 64'(bus.done), 1);
        chk("b2b.res1",  64'(bus.result), 32'h0F);
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b.done2", 64'(bus.done), 0);
        chk("b2b.hold",  64'(bus.result), 32'h0F);

        // reset mid-multiply, with start held high alongside reset
        bus.start = 1'b1; bus.alu_op = 2'b10; bus.func = 6'b011000; bus.a = 32'h1234; bus.b = 32'h5678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("rstmul.busy", 64'(bus.busy), 0);
        chk("rstmul.done", 64'(bus.done), 0);
        chk("rstmul.res",  64'(bus.result), 0);
        chk("rstmul.zero", 64'(bus.zero), 1);
        chk("rstmul.hi",   64'(bus.hi), 0);
        model_hi = '0;
        repeat (40) begin
            @(negedge clk);
            chk("rstmul.nodone", 64'(bus.done), 0);
        end

        // randomized ops against the model
        fl = '{6'h00, 6'h08, 6'h02, 6'h04, 6'h05, 6'h06, 6'h2A, 6'h0A, 6'h18};
        for (int n = 0; n < 200; n++) begin
            logic [1:0] op;
            logic [5:0] f;
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 8)];
            run_op(op, f, pick_operand(), pick_operand(), $sformatf("rnd%0d", n), e);
            chk_out($sformatf("rnd%0d", n), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (legal 8..64, even).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; operation and operands sampled on an edge with start=1 while busy=0.
REQ-005 alu_op  input  2  operation class: 00 add, 01 sub, 10 R-type (decode func), 11 I-type (decode func).
REQ-006 func  input  6  function code, used only when alu_op[1]=1.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 busy  output  1  multi-cycle operation in progress; start ignored.
REQ-009 done  output  1  one-cycle pulse; result/flags valid from this cycle.
REQ-010 result  output  WIDTH  result (product low half for mult).
REQ-011 hi  output  WIDTH  product high half; holds last value for other operations.
REQ-012 zero  output  1  result == 0.
REQ-013 overflow  output  1  signed overflow, add/sub only, else 0.
REQ-014 illegal  output  1  decoded function unsupported; qualified by done.

Function
REQ-015 Decode (func[3:0], x = don't care): x000 add; 0010 sub (R-type only; I-type -> illegal); x100 and; x101 or; x110 xor; 1010 slt; full func 011000 mult (R-type only, ALU_MUL_EN builds only); all others illegal.
REQ-016 States: IDLE, MUL, DONE; reset -> IDLE.
REQ-017 IDLE/DONE + start + single-cycle op (add/sub/and/or/xor/slt/illegal) -> DONE next edge, result/flags registered on that edge.
REQ-018 IDLE/DONE + start + mult -> MUL; a, b latched; cycle counter loaded WIDTH-1.
REQ-019 MUL: one unsigned shift-add step per cycle; after counter reaches 0 -> DONE; latency WIDTH+1 cycles from start edge to done.
REQ-020 DONE without start -> IDLE; done=1 only in DONE; busy=1 only in MUL.
REQ-021 Start in DONE cycle accepted (back-to-back ops, one per cycle for single-cycle ops).
REQ-022 Start while busy=1 ignored, no queueing; operand/opcode changes during MUL have no effect.
REQ-023 add/sub wrap modulo 2^WIDTH; overflow = operand signs equal (b inverted for sub) and result sign differs.
REQ-024 slt: signed compare, result = {WIDTH-1 zeros, a<b}; overflow=0.
REQ-025 Illegal op: result=0, hi unchanged, zero=1, overflow=0, illegal=1 in DONE.
REQ-026 mult: {hi,result} = a*b unsigned (2*WIDTH bits); zero reflects result only.
REQ-027 result, hi, zero, overflow, illegal hold until next DONE.

Reset
REQ-028 rst=1 on an edge: state IDLE, busy=0, done=0, result=0, hi=0, zero=1, overflow=0, illegal=0, counter=0.
REQ-029 rst mid-MUL aborts; no done pulse for the aborted operation; rst dominates simultaneous start.

Configuration
REQ-030 Macro ALU_MUL_EN: defined -> mult datapath, counter and MUL state built, behaviour per REQ-018/019/026.
REQ-031 ALU_MUL_EN undefined -> func 011000 decodes illegal (REQ-025, latency 1), hi held at 0, busy never asserts.

Verification
REQ-032 WIDTH=32, alu_op=00, a=0x7FFFFFFF, b=1, start -> next cycle done=1, result=0x80000000, overflow=1, zero=0.
REQ-033 alu_op=10, func=101010, a=0xFFFFFFFF, b=1 -> result=1; same with func=000010 (sub), a=5, b=5 -> result=0, zero=1.
REQ-034 ALU_MUL_EN, alu_op=10, func=011000, a=0xFFFFFFFF, b=2 -> busy 32 cycles, done at start+33, hi=1, result=0xFFFFFFFE; start pulsed mid-op ignored.
REQ-035 Back-to-back: add(3,4) then xor(0xF0,0xFF) on consecutive starts -> done two consecutive cycles, results 7 then 0x0F.
REQ-036 rst asserted 10 cycles into mult -> next cycle busy=0, result=0, zero=1, no done; I-type func=000010 -> illegal=1, result=0.
